// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage.
// Signed and unsigned operations, fixed 33-cycle latency, pipeline stall request.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     src_a,
    input  logic [WIDTH-1:0]     src_b,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 stall_req
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic                 div_q, div_d;          // op[1]; signedness is folded into the flags below
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic [WIDTH-1:0]     a_q, a_d;              // |multiplicand| or |dividend|
    logic [WIDTH-1:0]     b_q, b_d;              // |multiplier| or |divisor|
    logic [2*WIDTH-1:0]   acc_q, acc_d;          // product; low half doubles as dividend/quotient
    logic [WIDTH:0]       rem_q, rem_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 done_q, done_d;

    logic                 signed_op;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH+1:0]     div_shift, div_diff;
    logic [WIDTH-1:0]     quot_fix, rem_fix, orig_a;
    logic [2*WIDTH-1:0]   prod_fix, fin_result;

    // Operand conditioning and per-iteration datapath
    assign signed_op = ~op[0];
    assign abs_a     = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
    assign abs_b     = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;

    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q & {WIDTH{acc_q[0]}}};
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {2'b00, b_q};

    // Sign correction at the end; the dividend is rebuilt from its magnitude for divide-by-zero
    assign prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quot_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    assign orig_a    = sign_a_q ? -a_q : a_q;
    assign fin_result = !div_q         ? prod_fix :
                        (b_q == '0)    ? {orig_a, {WIDTH{1'b1}}} :
                                         {rem_fix, quot_fix};

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    div_d    = op[1];
                    sign_a_d = signed_op & src_a[WIDTH-1];
                    sign_b_d = signed_op & src_b[WIDTH-1];
                    a_d      = abs_a;
                    b_d      = abs_b;
                    acc_d    = op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (div_q) begin
                        rem_d = div_diff[WIDTH+1] ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (!abort) begin
                    result_d = fin_result;
                    done_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            div_q    <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign stall_req = (start & ~abort & (state_q == S_IDLE)) | busy;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        abort;
    logic        busy, done, stall_req;
    logic [63:0] result;

    int total = 0;
    int bad   = 0;
    logic [63:0] last_res;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .abort(abort),
        .busy(busy), .done(done), .result(result), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint sq, sr;
        logic [31:0] q, r;
        case (o)
            2'd0: return 64'(sa * sb);
            2'd1: return 64'(ua * ub);
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 2'd2) begin
                    sq = sa / sb; sr = sa % sb;
                    q = sq[31:0]; r = sr[31:0];
                end else begin
                    q = a / b; r = a % b;
                end
                return {r, q};
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one operation from the start cycle through done, checking latency,
    // busy/stall_req shape and result; optionally pulses start during RUN.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit pulse);
        int lat = 0;
        bit shape_bad = 0;
        logic [63:0] exp = model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1 chk({tag, ":stall_start"}, {63'd0, stall_req}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
        while (!done && lat < 40) begin
            if (!(busy && stall_req)) shape_bad = 1;
            start = (pulse && lat == 5);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, ":latency"}, 64'(lat), 64'd33);
        chk({tag, ":busy_shape"}, {63'd0, shape_bad}, 64'd0);
        chk({tag, ":result"}, result, exp);
        chk({tag, ":idle_at_done"}, {62'd0, busy, stall_req}, 64'd0);
        @(negedge clk);
        chk({tag, ":done_width"}, {63'd0, done}, 64'd0);
        last_res = exp;
    endtask

    initial begin
        bit saw_done;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0; src_a = '0; src_b = '0;
        last_res = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {result[31:0], 29'd0, busy, done, stall_req}, 64'd0);
        chk("reset_result", result, 64'd0);
        reset_n = 1'b1;

        do_op("mult_neg3x7",   2'd0, 32'hFFFF_FFFD, 32'd7, 0);
        chk("mult_neg3x7_const", result, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op("multu_max",     2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        chk("multu_max_const", result, 64'hFFFF_FFFE_0000_0001);
        do_op("divu_100_7",    2'd3, 32'd100, 32'd7, 0);
        chk("divu_100_7_const", result, {32'd2, 32'd14});
        do_op("div_m7_2",      2'd2, 32'hFFFF_FFF9, 32'd2, 1);
        chk("div_m7_2_const", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op("div_ovf",       2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf_const", result, {32'd0, 32'h8000_0000});
        do_op("divu_by0",      2'd3, 32'h64, 32'd0, 0);
        chk("divu_by0_const", result, {32'h64, 32'hFFFF_FFFF});
        do_op("div_by0",       2'd2, 32'hFFFF_FFF9, 32'd0, 0);
        chk("div_by0_const", result, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

        // abort at E10 of a MULT
        @(negedge clk);
        start = 1'b1; op = 2'd0; src_a = 32'd12345; src_b = 32'd678;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {62'd0, busy, done}, 64'd0);
        chk("abort_result", result, last_res);
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        chk("abort_no_done", {63'd0, saw_done}, 64'd0);
        do_op("after_abort", 2'd1, 32'hDEAD_BEEF, 32'h1234_5678, 0);

        // reset at E20 of a DIV
        @(negedge clk);
        start = 1'b1; op = 2'd2; src_a = 32'hFFFF_0000; src_b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midreset_flags", {61'd0, busy, done, stall_req}, 64'd0);
        chk("midreset_result", result, 64'd0);
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        chk("midreset_no_done", {63'd0, saw_done}, 64'd0);

        // start together with abort in IDLE
        @(negedge clk);
        start = 1'b1; abort = 1'b1; op = 2'd1; src_a = 32'd5; src_b = 32'd5;
        #1 chk("start_abort_stall", {63'd0, stall_req}, 64'd0);
        @(negedge clk);
        chk("start_abort_busy", {63'd0, busy}, 64'd0);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", {62'd0, busy, done}, 64'd0);

        // random operations, some with a zero divisor
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra = $urandom;
            logic [31:0] rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            do_op($sformatf("rand%0d", i), 2'($urandom), ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, in parallel with the ALU.
- Consumes operands and op from the ID/EX stage register. Produces the 64-bit {HI,LO} result that the EX/MEM stage register latches on its 64-bit result input.
- Holds the pipeline through stall_req while an operation is running. Upstream logic combines stall_req into the stage-register and PC write enables.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH. The whole block scales with WIDTH.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset; sampled on rising edge of clk
- start  input  1  request; sampled only in IDLE
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- src_a  input  WIDTH  multiplicand / dividend
- src_b  input  WIDTH  multiplier / divisor
- abort  input  1  flush; cancels the operation in flight
- busy  output  1  operation in progress
- done  output  1  one-cycle result-valid pulse
- result  output  2*WIDTH  {HI,LO}; MULT: product; DIV: {remainder, quotient}
- stall_req  output  1  combinational: (start & ~abort & idle) | busy

Behaviour:
- Reset, synchronous, with priority over everything: state=IDLE, busy=0, done=0, result=0, iteration counter=0, internal accumulators=0. Reset mid-operation discards the operation; no done pulse is produced.
- States: IDLE, RUN, FIN.
  - IDLE: at edge E0 with start=1 and abort=0:
    - Latch op.
    - Latch sign flags: sign_a=src_a[MSB], sign_b=src_b[MSB], for signed ops only.
    - Latch |src_a| and |src_b| for signed ops, raw values for unsigned.
    - Set counter=0, state=RUN, busy=1.
  - RUN: one radix-2 iteration per edge, at E1..E32; counter increments; after the iteration with counter=WIDTH-1, state becomes FIN.
    - Multiply: shift-add, 2*WIDTH-bit accumulator.
    - Divide: restoring; remainder register WIDTH+1 bits, quotient shifted in from LSB.
  - FIN: at edge E33, result is written with sign correction applied, busy=0, done=1, state=IDLE.
- Sign correction:
  - MULT: negate the 2*WIDTH-bit product if sign_a^sign_b.
  - DIV: negate the quotient if sign_a^sign_b; negate the remainder if sign_a. The remainder takes the dividend's sign.
- Fixed latency: done is high in the cycle after E33, i.e. 33 edges after the start edge. It is 1 cycle wide and cleared at the next edge.
- result holds its value until the next FIN write or reset. It is not cleared by abort or by a new start.
- Divide by zero (src_b=0, DIV or DIVU): quotient = all ones, remainder = original src_a, unmodified by sign logic. Same 33-edge latency.
- DIV 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. This falls out of the abs/negate path with no special case.
- start while busy or in FIN: ignored. No queueing; operands are not re-sampled.
- abort:
  - In RUN or FIN: state=IDLE and busy=0 at the next edge. No done pulse; result unchanged.
  - In IDLE together with start: abort wins, no operation starts, and stall_req=0.
- stall_req is high in the start cycle itself, so the ID/EX register does not advance. It then stays high while busy=1 and drops in the done cycle, when EX/MEM latches result.
- Operand inputs need only be valid in the start cycle.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=7 -> done exactly 33 edges after start; result=0xFFFFFFFF_FFFFFFEB; busy high edges E0..E33; stall_req high from the start cycle until done.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE_00000001. DIVU 100/7 -> result={0x00000002, 0x0000000E}.
- DIV -7/2 (0xFFFFFFF9, 2) -> result={0xFFFFFFFF, 0xFFFFFFFD}. DIV 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}.
- DIVU 0x64/0 and DIV 0xFFFFFFF9/0 -> {0x00000064, 0xFFFFFFFF} and {0xFFFFFFF9, 0xFFFFFFFF}; latency 33.
- Abort at E10 of a MULT -> busy=0 next cycle; no done; result keeps its prior value. A new start 2 cycles later with different operands -> correct result 33 edges later. start pulses during RUN are ignored.
- reset_n=0 for 1 cycle at E20 of a DIV -> all outputs 0 next cycle; no done pulse ever. start+abort together in IDLE -> no busy, stall_req=0.
